// File: rtl/sm4_apb_regif.sv
// APB register interface for the SM4 core: register file, key/work sequencing and interrupt.
// Reads insert RD_WAIT wait states; writes complete in the first access cycle.
module sm4_apb_regif #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic         io_mainClk,
  input  logic         resetCtrl_systemReset_n,
  input  logic [11:0]  io_apb_PADDR,
  input  logic         io_apb_PSEL,
  input  logic         io_apb_PENABLE,
  input  logic         io_apb_PWRITE,
  input  logic [31:0]  io_apb_PWDATA,
  output logic [31:0]  io_apb_PRDATA,
  output logic         io_apb_PREADY,
  output logic         io_apb_PSLVERROR,
  output logic [3:0]   o_sm4_mode,
  output logic [127:0] o_data,
  output logic [127:0] o_key,
  output logic [6:0]   o_rom_addr,
  output logic         o_key_start,
  output logic         o_work_start,
  input  logic         i_key_done,
  input  logic         i_work_done,
  input  logic [127:0] i_result,
  output logic         io_SM4_interrupt
);

  typedef enum logic [1:0] {StIdle, StKeyBusy, StWorkBusy} state_e;

  localparam logic [1:0] RdWait = 2'(RD_WAIT);

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d, key_q, key_d, res_q, res_d;
  logic [3:0]   mode_q, mode_d;
  logic [6:0]   rom_q, rom_d;
  logic         key_valid_q, key_valid_d, irq_q, irq_d;
  logic         key_start_q, key_start_d, work_start_q, work_start_d;
  logic [1:0]   wait_q, wait_d;

  logic [11:0] addr;
  logic        aligned, in_data, in_res, in_key, is_work, is_kinit, is_mode, is_rom, is_stat;
  logic        mapped, access, ready, wr, rd_done, busy, err, wr_ok, wbit, key_go, work_go;
  logic        irq_clr;
  logic [1:0]  data_idx, res_idx, key_idx;
  logic [31:0] rdata;

  assign addr     = io_apb_PADDR;
  assign aligned  = addr[1:0] == 2'b00;
  assign in_data  = aligned && addr >= 12'h104 && addr <= 12'h110;
  assign in_res   = aligned && addr >= 12'h118 && addr <= 12'h124;
  assign in_key   = aligned && addr >= 12'h138 && addr <= 12'h144;
  assign is_work  = addr == 12'h114;
  assign is_kinit = addr == 12'h148;
  assign is_mode  = addr == 12'h14C;
  assign is_rom   = addr == 12'h150;
  assign is_stat  = addr == 12'h154;
  assign mapped   = in_data | in_res | in_key | is_work | is_kinit | is_mode | is_rom | is_stat;

  // Word index within each bank; the bank bases are not 16-byte aligned.
  assign data_idx = addr[3:2] - 2'd1;
  assign res_idx  = addr[3:2] - 2'd2;
  assign key_idx  = addr[3:2] - 2'd2;

  assign busy    = state_q != StIdle;
  assign access  = io_apb_PSEL & io_apb_PENABLE;
  assign ready   = access & (io_apb_PWRITE | (wait_q == RdWait));
  assign wr      = ready & io_apb_PWRITE;
  assign rd_done = ready & ~io_apb_PWRITE;
  assign wbit    = io_apb_PWDATA[0];

  always_comb begin
    err = 1'b0;
    if (!mapped) begin
      err = 1'b1;
    end else if (io_apb_PWRITE) begin
      if (in_res || (busy && !is_stat)) begin
        err = 1'b1;
      end else if (is_kinit && wbit && !(mode_q inside {4'h0, 4'h1, 4'h2})) begin
        err = 1'b1;
      end else if (is_work && wbit && !(key_valid_q && (mode_q == 4'h4 || mode_q == 4'h8))) begin
        err = 1'b1;
      end
    end
  end

  assign wr_ok   = wr & ~err;
  assign key_go  = wr_ok & is_kinit & wbit;
  assign work_go = wr_ok & is_work & wbit;

  always_comb begin
    rdata = '0;
    if (in_data)  rdata = data_q[{data_idx, 5'd0} +: 32];
    if (in_res)   rdata = res_q[{~res_idx, 5'd0} +: 32];
    if (in_key)   rdata = key_q[{key_idx, 5'd0} +: 32];
    if (is_work)  rdata = {30'd0, key_valid_q, busy};
    if (is_mode)  rdata = {28'd0, mode_q};
    if (is_rom)   rdata = {25'd0, rom_q};
    if (is_stat)  rdata = {29'd0, irq_q, key_valid_q, busy};
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    key_d        = key_q;
    res_d        = res_q;
    mode_d       = mode_q;
    rom_d        = rom_q;
    key_valid_d  = key_valid_q;
    irq_d        = irq_q;
    key_start_d  = 1'b0;
    work_start_d = 1'b0;
    wait_d       = (access & ~io_apb_PWRITE & ~ready) ? wait_q + 2'd1 : 2'd0;

    if (wr_ok) begin
      if (in_data) data_d[{data_idx, 5'd0} +: 32] = io_apb_PWDATA;
      if (in_key)  key_d[{key_idx, 5'd0} +: 32] = io_apb_PWDATA;
      if (is_mode) mode_d = io_apb_PWDATA[3:0];
      if (is_rom)  rom_d = io_apb_PWDATA[6:0];
    end

    irq_clr = (rd_done & (addr == 12'h124)) | (wr_ok & is_stat & wbit) | work_go;
    if (irq_clr) irq_d = 1'b0;

    // Completion is evaluated after the clears so a same-cycle set wins.
    unique case (state_q)
      StIdle: begin
        if (key_go) begin
          key_start_d = 1'b1;
          key_valid_d = 1'b0;
          state_d     = StKeyBusy;
        end else if (work_go) begin
          work_start_d = 1'b1;
          state_d      = StWorkBusy;
        end
      end
      StKeyBusy: begin
        if (i_key_done) begin
          key_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StWorkBusy: begin
        if (i_work_done) begin
          res_d   = i_result;
          irq_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemReset_n) begin
    if (!resetCtrl_systemReset_n) begin
      state_q      <= StIdle;
      data_q       <= '0;
      key_q        <= '0;
      res_q        <= '0;
      mode_q       <= '0;
      rom_q        <= '0;
      key_valid_q  <= 1'b0;
      irq_q        <= 1'b0;
      key_start_q  <= 1'b0;
      work_start_q <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      key_q        <= key_d;
      res_q        <= res_d;
      mode_q       <= mode_d;
      rom_q        <= rom_d;
      key_valid_q  <= key_valid_d;
      irq_q        <= irq_d;
      key_start_q  <= key_start_d;
      work_start_q <= work_start_d;
      wait_q       <= wait_d;
    end
  end

  assign io_apb_PREADY    = ready;
  assign io_apb_PRDATA    = rd_done ? rdata : '0;
  assign io_apb_PSLVERROR = ready & err;
  assign o_sm4_mode       = mode_q;
  assign o_data           = data_q;
  assign o_key            = key_q;
  assign o_rom_addr       = rom_q;
  assign o_key_start      = key_start_q;
  assign o_work_start     = work_start_q;
  assign io_SM4_interrupt = irq_q;

endmodule

// File: tb/tb_sm4_apb_regif.sv
// Bench for sm4_apb_regif: register-map model checked every cycle on instance 0 (RD_WAIT=1);
// instances 1 and 2 (RD_WAIT=0, 3) exercise read/write timing.
module tb_sm4_apb_regif;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [11:0]  paddr;
  logic [2:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  pwdata;
  logic         key_done, work_done;
  logic [127:0] result;

  logic [31:0]  prdata_w [3];
  logic         pready_w [3];
  logic         pslverr_w [3];
  logic [3:0]   mode_w [3];
  logic [127:0] data_w [3];
  logic [127:0] key_w [3];
  logic [6:0]   rom_w [3];
  logic         kstart_w [3];
  logic         wstart_w [3];
  logic         irq_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sm4_apb_regif #(.RD_WAIT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
      .io_mainClk              (clk),
      .resetCtrl_systemReset_n (rst_n),
      .io_apb_PADDR            (paddr),
      .io_apb_PSEL             (psel[g]),
      .io_apb_PENABLE          (penable),
      .io_apb_PWRITE           (pwrite),
      .io_apb_PWDATA           (pwdata),
      .io_apb_PRDATA           (prdata_w[g]),
      .io_apb_PREADY           (pready_w[g]),
      .io_apb_PSLVERROR        (pslverr_w[g]),
      .o_sm4_mode              (mode_w[g]),
      .o_data                  (data_w[g]),
      .o_key                   (key_w[g]),
      .o_rom_addr              (rom_w[g]),
      .o_key_start             (kstart_w[g]),
      .o_work_start            (wstart_w[g]),
      .i_key_done              (key_done),
      .i_work_done             (work_done),
      .i_result                (result),
      .io_SM4_interrupt        (irq_w[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of instance 0.
  logic [31:0] m_data [4];
  logic [31:0] m_key [4];
  logic [31:0] m_res [4];
  logic [3:0]  m_mode;
  logic [6:0]  m_rom;
  logic        m_kv, m_irq;
  int          m_busy;  // 0 idle, 1 key schedule, 2 block operation
  int          key_pulse_cyc, work_pulse_cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_key[i]  = '0;
      m_res[i]  = '0;
    end
    m_mode = '0;
    m_rom = '0;
    m_kv = 1'b0;
    m_irq = 1'b0;
    m_busy = 0;
    key_pulse_cyc = -10;
    work_pulse_cyc = -10;
  endfunction

  // 0 unmapped, 1 DATA, 2 WORK, 3 RES, 4 KEY, 5 KINIT, 6 MODE, 7 ROMADDR, 8 STAT
  function automatic int kind_of(input logic [11:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a >= 12'h104 && a <= 12'h110) return 1;
    if (a == 12'h114) return 2;
    if (a >= 12'h118 && a <= 12'h124) return 3;
    if (a >= 12'h138 && a <= 12'h144) return 4;
    if (a == 12'h148) return 5;
    if (a == 12'h14C) return 6;
    if (a == 12'h150) return 7;
    if (a == 12'h154) return 8;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int k = kind_of(a);
    case (k)
      1: return m_data[(int'(a) - 'h104) / 4];
      2: return {30'd0, m_kv, m_busy != 0};
      3: return m_res[(int'(a) - 'h118) / 4];
      4: return m_key[(int'(a) - 'h138) / 4];
      6: return {28'd0, m_mode};
      7: return {25'd0, m_rom};
      8: return {29'd0, m_irq, m_kv, m_busy != 0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_wr_err(input logic [11:0] a, input logic [31:0] v);
    int k = kind_of(a);
    if (k == 0 || k == 3) return 1'b1;
    if (m_busy != 0 && k != 8) return 1'b1;
    if (k == 5 && v[0] && m_mode > 4'd2) return 1'b1;
    if (k == 2 && v[0] && !(m_kv && (m_mode == 4'd4 || m_mode == 4'd8))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
    case (kind_of(a))
      1: m_data[(int'(a) - 'h104) / 4] = v;
      4: m_key[(int'(a) - 'h138) / 4] = v;
      6: m_mode = v[3:0];
      7: m_rom = v[6:0];
      8: if (v[0]) m_irq = 1'b0;
      5: if (v[0]) begin m_kv = 1'b0; m_busy = 1; key_pulse_cyc = cyc; end
      2: if (v[0]) begin m_irq = 1'b0; m_busy = 2; work_pulse_cyc = cyc; end
      default: ;
    endcase
  endfunction

  function automatic void m_done(input logic [127:0] r);
    for (int i = 0; i < 4; i++) m_res[i] = r[127 - 32 * i -: 32];
    m_irq = 1'b1;
    m_busy = 0;
  endfunction

  // Per-cycle comparison of instance 0 against the model.
  always @(negedge clk) begin
    chk("o_data", data_w[0], {m_data[3], m_data[2], m_data[1], m_data[0]});
    chk("o_key", key_w[0], {m_key[3], m_key[2], m_key[1], m_key[0]});
    chk("o_sm4_mode", mode_w[0], m_mode);
    chk("o_rom_addr", rom_w[0], m_rom);
    chk("irq", irq_w[0], m_irq);
    chk("o_key_start", kstart_w[0], cyc == key_pulse_cyc);
    chk("o_work_start", wstart_w[0], cyc == work_pulse_cyc);
    if (!pready_w[0]) begin
      chk("prdata_not_ready", prdata_w[0], 0);
      chk("pslverr_not_ready", pslverr_w[0], 0);
    end
    if (!(psel[0] && penable)) chk("pready_idle", pready_w[0], 0);
  end

  task automatic apb_wr(input int d, input logic [11:0] a, input logic [31:0] v,
                        output logic err);
    logic e_exp = 1'b1;
    @(posedge clk); #1;
    paddr = a; pwrite = 1'b1; pwdata = v; psel = '0; psel[d] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("wr_pready", pready_w[d], 1);
    err = pslverr_w[d];
    if (d == 0) begin
      e_exp = m_wr_err(a, v);
      chk("wr_err", err, e_exp);
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    if (d == 0 && !e_exp) m_write(a, v);
  endtask

  task automatic apb_rd(input int d, input logic [11:0] a, input logic with_done,
                        output logic [31:0] rd, output logic err, output int waits);
    logic [31:0] exp_rd = m_read(a);
    @(posedge clk); #1;
    paddr = a; pwrite = 1'b0; psel = '0; psel[d] = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (pready_w[d]) break;
      chk("rd_wait_prdata", prdata_w[d], 0);
      waits++;
      if (waits > 8) begin
        chk("rd_timeout", 0, 1);
        break;
      end
    end
    rd = prdata_w[d];
    err = pslverr_w[d];
    if (with_done) work_done = 1'b1;
    if (d == 0) begin
      chk("rd_data", rd, exp_rd);
      chk("rd_err", err, kind_of(a) == 0);
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0; work_done = 1'b0;
    if (d == 0 && a == 12'h124) m_irq = 1'b0;
    if (with_done && m_busy == 2) m_done(result);
  endtask

  task automatic pulse_key_done();
    @(posedge clk); #1 key_done = 1'b1;
    @(posedge clk); #1 key_done = 1'b0;
    if (m_busy == 1) begin m_kv = 1'b1; m_busy = 0; end
  endtask

  task automatic pulse_work_done(input logic [127:0] r);
    @(posedge clk); #1 result = r; work_done = 1'b1;
    @(posedge clk); #1 work_done = 1'b0;
    if (m_busy == 2) m_done(r);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          w;
    int          ew [3] = '{1, 0, 3};
    logic [31:0] res_exp [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    key_done = 1'b0; work_done = 1'b0; result = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("reset_stat", rd, 32'h0);
    apb_rd(0, 12'h104, 1'b0, rd, e, w); chk("reset_data0", rd, 32'h0);
    apb_rd(0, 12'h118, 1'b0, rd, e, w); chk("reset_res0", rd, 32'h0);

    // Start preconditions failing
    apb_wr(0, 12'h14C, 32'h8, e);
    apb_wr(0, 12'h114, 32'h1, e); chk("work_no_key_err", e, 1);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_after_bad_work", rd, 32'h0);
    apb_wr(0, 12'h148, 32'h1, e); chk("kinit_bad_mode_err", e, 1);

    // Direct key
    apb_wr(0, 12'h138, 32'h01234567, e);
    apb_wr(0, 12'h13C, 32'h89ABCDEF, e);
    apb_wr(0, 12'h140, 32'hFEDCBA98, e);
    apb_wr(0, 12'h144, 32'h76543210, e);
    apb_wr(0, 12'h14C, 32'h0, e);
    apb_wr(0, 12'h150, 32'h5A, e);
    apb_wr(0, 12'h148, 32'h1, e); chk("kinit_ok", e, 0);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_key_busy", rd, 32'h1);
    pulse_key_done();
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_key_valid", rd, 32'h2);

    // Encrypt
    apb_wr(0, 12'h14C, 32'h8, e);
    apb_wr(0, 12'h104, 32'hA0A1A2A3, e);
    apb_wr(0, 12'h108, 32'hB0B1B2B3, e);
    apb_wr(0, 12'h10C, 32'hC0C1C2C3, e);
    apb_wr(0, 12'h110, 32'hD0D1D2D3, e);
    @(negedge clk);
    chk("o_data_literal", data_w[0], 128'hD0D1D2D3_C0C1C2C3_B0B1B2B3_A0A1A2A3);
    apb_wr(0, 12'h114, 32'h1, e); chk("work_ok", e, 0);
    apb_wr(0, 12'h104, 32'hDEADBEEF, e); chk("data_busy_err", e, 1);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_work_busy", rd, 32'h3);
    pulse_work_done(128'h00112233_44556677_8899AABB_CCDDEEFF);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_irq", rd, 32'h6);
    for (int i = 0; i < 4; i++) begin
      apb_rd(0, 12'(12'h118 + 4 * i), 1'b0, rd, e, w);
      chk("res_word", rd, res_exp[i]);
    end
    @(negedge clk); chk("irq_cleared_by_res3", irq_w[0], 0);

    // Misc errors and no-ops
    apb_wr(0, 12'h114, 32'h0, e); chk("work_noop", e, 0);
    apb_wr(0, 12'h14C, 32'h1, e);
    apb_wr(0, 12'h114, 32'h1, e); chk("work_bad_mode_err", e, 1);
    apb_wr(0, 12'h118, 32'h1, e); chk("res_write_err", e, 1);
    apb_rd(0, 12'h105, 1'b0, rd, e, w); chk("unaligned_err", e, 1);
    apb_rd(0, 12'h200, 1'b0, rd, e, w); chk("unmapped_err", e, 1);
    chk("unmapped_prdata", rd, 32'h0);
    apb_wr(0, 12'h200, 32'h1, e); chk("unmapped_wr_err", e, 1);

    // Stray completions while idle are ignored
    pulse_key_done();
    pulse_work_done(128'hFFFF);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_stray_done", rd, 32'h2);

    // STAT write clears irq
    apb_wr(0, 12'h14C, 32'h4, e);
    apb_wr(0, 12'h114, 32'h1, e);
    pulse_work_done(128'h1);
    @(negedge clk); chk("irq_decrypt_done", irq_w[0], 1);
    apb_wr(0, 12'h154, 32'h1, e);
    @(negedge clk); chk("irq_stat_clear", irq_w[0], 0);

    // Completion collides with the RES3 read: set wins
    apb_wr(0, 12'h14C, 32'h8, e);
    apb_wr(0, 12'h114, 32'h1, e);
    result = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF;
    apb_rd(0, 12'h124, 1'b1, rd, e, w); chk("collision_old_res3", rd, 32'h1);
    @(negedge clk); chk("collision_irq", irq_w[0], 1);
    apb_rd(0, 12'h124, 1'b0, rd, e, w); chk("collision_new_res3", rd, 32'h0BADBEEF);

    // Read/write timing for each wait-state setting
    for (int d = 0; d < 3; d++) begin
      apb_wr(d, 12'h14C, 32'h5, e);
      apb_rd(d, 12'h14C, 1'b0, rd, e, w);
      chk("rd_waits", w, ew[d]);
      chk("rd_mode_value", rd, 32'h5);
    end

    // Reset in the middle of a block operation
    apb_wr(0, 12'h14C, 32'h8, e);
    apb_wr(0, 12'h114, 32'h1, e);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_work_done(128'h77);
    apb_rd(0, 12'h154, 1'b0, rd, e, w); chk("stat_after_reset", rd, 32'h0);
    @(negedge clk); chk("irq_after_reset", irq_w[0], 0);
    apb_rd(0, 12'h118, 1'b0, rd, e, w); chk("res0_after_reset", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
